acia_rx: RTL
============

# acia_rx

Receive half of the serial controller that consumes the serial ULA's `RxC`/`RxD`/`DCD` outputs, for both cassette and RS423 paths. It synchronises the externally generated receive clock and data into the `clk` domain and detects start bits. It deserialises 8N1 characters LSB-first and presents each completed byte with RDRF, framing-error, overrun and carrier-loss status to the CPU-side register file.

## Interface
- `DATA_BITS`, default 8: data bits per character; fixed at 8 for this design, kept as a parameter for the bench only.
- `clk`  input  1  fast system clock (16/13 MHz); all state changes on its rising edge.
- `nRESET`  input  1  asynchronous, active-low reset.
- `div_sel`  input  2  clock divide select: 00 = ÷1, 01 = ÷16, 10 = ÷64, 11 = receiver held idle (master reset).
- `RxC`  input  1  receive clock from the ULA, asynchronous to `clk`.
- `RxD`  input  1  receive data from the ULA, asynchronous to `clk`; idle high.
- `DCD`  input  1  carrier-loss indication, active high, asynchronous.
- `rd_strobe`  input  1  one-cycle pulse: CPU read of the receive data register.
- `rx_data`  output  8  last accepted character.
- `rdrf`  output  1  receive data register full.
- `fe`  output  1  framing error for the character in `rx_data`.
- `ovrn`  output  1  overrun: a character was lost while `rdrf` was set.
- `dcd_flag`  output  1  sticky: carrier lost since the last read.

## Operation
- Synchronisers: `RxC`, `RxD` and `DCD` each pass through 2 flops (s1, s2). `RxC` has a third flop s3.
- `tick` = s2 & !s3 on `RxC`. It is a one-cycle pulse per rising `RxC` edge. Data is sampled from synchronised `RxD` s2 in the tick cycle.
- `N` = 1, 16 or 64 from `div_sel`. `H` = N/2, with ÷1 treated as H = 0. The tick counter is 6 bits and wraps 63→0 only under explicit reload.
- State machine states: IDLE, START, DATA, STOP. All transitions occur only on `tick`, except for abort.
- IDLE: on a tick with RxD = 0, go to START and clear the counter. For ÷1, go directly to DATA with bit index 0.
- START (÷16/÷64): count ticks.
  - On the H-th tick after entry, if RxD = 0, go to DATA and clear the counter.
  - If RxD = 1 on that tick, it is a false start: return to IDLE.
- DATA: sample at counter = N−1, i.e. the bit centre, then clear the counter. Shift right into an 8-bit shift register (LSB first). After 8 samples, go to STOP.
- STOP: sample at the same point as DATA. On that tick, complete the character and go to IDLE.
- Completion:
  - If `rdrf` = 0 or `rd_strobe` = 1 in the same cycle, load `rx_data` and set `rdrf` = 1. Set `fe` = !RxD(stop sample). Clear `ovrn`.
  - Otherwise, keep `rx_data` and `fe` unchanged and set `ovrn` = 1.
- `rd_strobe` without completion clears `rdrf`, `fe`, `ovrn` and `dcd_flag`. `rx_data` holds its value.
- Carrier loss: synchronised DCD = 1 forces IDLE every cycle, aborting any partial character. The partial character is discarded and no flags are changed except `dcd_flag`, which is set.
  - DCD = 1 and `rd_strobe` in the same cycle: `dcd_flag` stays 1.
- `div_sel` = 11: same abort as DCD, but `dcd_flag` is not set. A `div_sel` change mid-character takes effect on the next tick, with no abort. Behaviour for that character is undefined; the bench must not check it.

## Timing
- Reset (async assert, sync to nothing): state = IDLE, counter = 0, shift register = 0. `rx_data` = 0x00; `rdrf`, `fe`, `ovrn`, `dcd_flag` = 0. All synchroniser flops reset to 1 except DCD, which resets to 0.
- Reset mid-character discards the character; no flag is set after release.
- `RxC` rising edge to `tick`: 2–3 `clk` cycles.
- Stop-sample tick to `rdrf`/`rx_data`/`fe`/`ovrn` update: 1 `clk` (registered on the tick edge).
- `RxC` high and low phases must each be ≥ 2 `clk` periods. Faster clocks are out of spec.
- `rd_strobe` effect is visible the cycle after the strobe.
- DCD assertion to IDLE: 3 `clk` cycles.

## Test plan
- ÷16, send 0xA5 (start, 1010_0101 LSB first, stop = 1), 16 ticks/bit -> `rx_data` = 0xA5, `rdrf` = 1, `fe` = 0, `ovrn` = 0 one clk after the stop-centre tick.
- ÷16, RxD low for 4 ticks then high -> stays IDLE; `rdrf` = 0. Then a valid 0x3C -> `rx_data` = 0x3C.
- ÷64, send 0x81 with stop = 0 -> `rx_data` = 0x81, `fe` = 1, `rdrf` = 1. Then `rd_strobe` -> `rdrf` = `fe` = 0, `rx_data` still 0x81.
- ÷1, send 0x55 then 0xAA with no read -> `rx_data` = 0x55, `ovrn` = 1. Read plus completion in the same cycle -> new byte loaded, `rdrf` = 1, `ovrn` = 0.
- ÷16, assert DCD after 3 data bits of 0xFF, release, send 0x12 -> `dcd_flag` = 1, first byte never appears, `rx_data` = 0x12.
- Pulse `nRESET` low mid-character -> all outputs at their reset values. A subsequent 0x7E is received correctly.

Source files
------------

// File: rtl/acia_rx.sv
// ---------------------------------------------------------------------------
// acia_rx -- receive half of the serial controller.
//
// Synchronises the ULA's RxC/RxD/DCD into the clk domain, turns each rising
// RxC edge into a one-cycle tick, and deserialises 8N1 characters LSB-first
// at a divide ratio of 1, 16 or 64 ticks per bit. Each completed character
// is presented with RDRF, framing-error, overrun and carrier-loss status.
//
// Ports:
//   clk        system clock; all state changes on its rising edge
//   nRESET     asynchronous active-low reset
//   div_sel    00 = /1, 01 = /16, 10 = /64, 11 = receiver held idle
//   RxC        receive clock from the ULA (asynchronous)
//   RxD        receive data from the ULA (asynchronous, idle high)
//   DCD        carrier loss, active high (asynchronous)
//   rd_strobe  one-cycle CPU read of the receive data register
//   rx_data    last accepted character
//   rdrf       receive data register full
//   fe         framing error for the character in rx_data
//   ovrn       a character was lost while rdrf was set
//   dcd_flag   sticky carrier-loss flag, cleared by a read once DCD drops
// ---------------------------------------------------------------------------
module acia_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 nRESET,
    input  logic [1:0]           div_sel,
    input  logic                 RxC,
    input  logic                 RxD,
    input  logic                 DCD,
    input  logic                 rd_strobe,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdrf,
    output logic                 fe,
    output logic                 ovrn,
    output logic                 dcd_flag
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // Synchroniser chains; RxC carries a third stage for edge detection.
    logic rxc_s1_q, rxc_s2_q, rxc_s3_q;
    logic rxd_s1_q, rxd_s2_q;
    logic dcd_s1_q, dcd_s2_q;

    state_e               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rdrf_q, rdrf_d;
    logic                 fe_q, fe_d;
    logic                 ovrn_q, ovrn_d;
    logic                 dcd_flag_q, dcd_flag_d;

    logic       tick;
    logic       abort;
    logic       done;
    logic [5:0] n_m1;   // ticks per bit minus one: bit-centre sample point
    logic [5:0] h_m1;   // half-bit ticks minus one: start-bit centre

    assign tick  = rxc_s2_q & ~rxc_s3_q;
    assign abort = dcd_s2_q | (div_sel == 2'b11);

    always_comb begin
        case (div_sel)
            2'b01:   begin n_m1 = 6'd15; h_m1 = 6'd7;  end
            2'b10:   begin n_m1 = 6'd63; h_m1 = 6'd31; end
            default: begin n_m1 = 6'd0;  h_m1 = 6'd0;  end
        endcase
    end

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
        if (abort) begin
            // Carrier loss or master reset: drop any partial character.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s2_q) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        // At /1 there is no start-bit centre to find.
                        state_d = (div_sel == 2'b00) ? S_DATA : S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == h_m1) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rxd_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == n_m1) begin
                        cnt_d   = '0;
                        shift_d = {rxd_s2_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == n_m1) begin
                        cnt_d   = '0;
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // CPU-side register file. A read in the completion cycle frees the
    // holding register, so the new character is accepted instead of lost.
    always_comb begin
        rx_data_d  = rx_data_q;
        rdrf_d     = rdrf_q;
        fe_d       = fe_q;
        ovrn_d     = ovrn_q;
        dcd_flag_d = dcd_flag_q;
        if (done) begin
            if (!rdrf_q || rd_strobe) begin
                rx_data_d = shift_q;
                rdrf_d    = 1'b1;
                fe_d      = ~rxd_s2_q;
                ovrn_d    = 1'b0;
            end else begin
                ovrn_d = 1'b1;
            end
        end else if (rd_strobe) begin
            rdrf_d = 1'b0;
            fe_d   = 1'b0;
            ovrn_d = 1'b0;
        end
        // Live carrier loss wins over a read so the event cannot be missed.
        if (dcd_s2_q) begin
            dcd_flag_d = 1'b1;
        end else if (rd_strobe) begin
            dcd_flag_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs, which is what makes the chains work.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            rxc_s1_q <= 1'b1;
            rxc_s2_q <= 1'b1;
            rxc_s3_q <= 1'b1;
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            dcd_s1_q <= 1'b0;
            dcd_s2_q <= 1'b0;
        end else begin
            rxc_s1_q <= RxC;
            rxc_s2_q <= rxc_s1_q;
            rxc_s3_q <= rxc_s2_q;
            rxd_s1_q <= RxD;
            rxd_s2_q <= rxd_s1_q;
            dcd_s1_q <= DCD;
            dcd_s2_q <= dcd_s1_q;
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rdrf_q     <= 1'b0;
            fe_q       <= 1'b0;
            ovrn_q     <= 1'b0;
            dcd_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdrf_q     <= rdrf_d;
            fe_q       <= fe_d;
            ovrn_q     <= ovrn_d;
            dcd_flag_q <= dcd_flag_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rdrf     = rdrf_q;
    assign fe       = fe_q;
    assign ovrn     = ovrn_q;
    assign dcd_flag = dcd_flag_q;

endmodule
